// File: rtl/otter_pipe_pkg.sv
// Shared opcode constants and hazard FSM state encoding for the Otter pipeline.
// Latency: none (declarations only).
// Backpressure: not applicable.
package otter_pipe_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_REDIRECT = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// Flags an ID-stage instruction that reads the destination of a load sitting in EX.
// Latency: purely combinational, same cycle.
// Backpressure: none; the caller decides whether the flag stalls anything.
module load_use_detect
  import otter_pipe_pkg::*;
(
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic        valid_E,
  output logic        load_use
);

  logic [6:0] w_op_d;
  logic [6:0] w_op_e;
  logic [4:0] w_rd_e;
  logic [4:0] w_rs1_d;
  logic [4:0] w_rs2_d;
  logic       w_rs1_used;
  logic       w_rs2_used;
  logic       w_rs1_hit;
  logic       w_rs2_hit;
  logic       w_unused_ir;

  assign w_op_d  = IR_D[6:0];
  assign w_rs1_d = IR_D[19:15];
  assign w_rs2_d = IR_D[24:20];
  assign w_op_e  = IR_E[6:0];
  assign w_rd_e  = IR_E[11:7];

  // Immediate/funct bits never take part in the register compare.
  assign w_unused_ir = ^{IR_D[31:25], IR_D[14:7], IR_E[31:12]};

  // U-type and JAL carry immediate bits where rs1 would be.
  assign w_rs1_used = (w_op_d != OP_LUI) && (w_op_d != OP_AUIPC) && (w_op_d != OP_JAL);
  // Only R-type, store and branch actually read rs2; elsewhere those bits are immediate.
  assign w_rs2_used = (w_op_d == OP_RTYPE) || (w_op_d == OP_STORE) || (w_op_d == OP_BRANCH);

  assign w_rs1_hit = w_rs1_used && (w_rs1_d == w_rd_e);
  assign w_rs2_hit = w_rs2_used && (w_rs2_d == w_rd_e);

  // x0 is never a real dependency, so a load into x0 cannot cause a stall.
  assign load_use = valid_E && (w_op_e == OP_LOAD) && (w_rd_e != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage Otter: PC/IF-ID enables, flushes, EX-MEM hold, redirect select, event counters.
// Latency: control outputs are Mealy (same cycle as cause); state, flush_left and counters update on CLK rise.
// Backpressure: a pending data-memory access (dmem_req & !dmem_ack) freezes the pipe and defers redirect/load-use.
module pipeline_hazard_controller
  import otter_pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [31:0]      IR_D,
  input  logic [31:0]      IR_E,
  input  logic             valid_E,
  input  logic             take_branch,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_hold,
  output logic             pc_redirect,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state
);

  // Squash cycles still owed after the redirect cycle itself.
  localparam logic [2:0] LP_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  hz_state_t        r_state;
  logic [2:0]       r_flush_left;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  hz_state_t        w_state_nxt;
  logic [2:0]       w_flush_left_nxt;
  logic [6:0]       w_op_e;
  logic             w_mem_stall;
  logic             w_redirect;
  logic             w_load_use;
  logic             w_redirect_evt;

  assign w_op_e      = IR_E[6:0];
  assign w_mem_stall = dmem_req && !dmem_ack;
  assign w_redirect  = valid_E && ((w_op_e == OP_JAL) || (w_op_e == OP_JALR) ||
                                   ((w_op_e == OP_BRANCH) && take_branch));
  // A redirect only takes effect when EX is not frozen by memory.
  assign w_redirect_evt = w_redirect && !w_mem_stall;

  load_use_detect u_load_use_detect (
    .IR_D     (IR_D),
    .IR_E     (IR_E),
    .valid_E  (valid_E),
    .load_use (w_load_use)
  );

  // State register: FSM state and remaining squash count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= HZ_RUN;
      r_flush_left <= 3'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_left <= w_flush_left_nxt;
    end
  end

  // Next state: memory stall wins, then a new redirect, then the per-state default.
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_left_nxt = r_flush_left;
    if (w_mem_stall) begin
      // flush_left is frozen so an interrupted squash resumes after the ack.
      w_state_nxt = HZ_MEM_WAIT;
    end else if (w_redirect) begin
      w_flush_left_nxt = LP_FLUSH_RELOAD;
      w_state_nxt      = (LP_FLUSH_RELOAD != 3'd0) ? HZ_REDIRECT : HZ_RUN;
    end else begin
      case (r_state)
        HZ_REDIRECT: begin
          if (r_flush_left > 3'd1) begin
            w_flush_left_nxt = r_flush_left - 3'd1;
            w_state_nxt      = HZ_REDIRECT;
          end else begin
            w_flush_left_nxt = 3'd0;
            w_state_nxt      = HZ_RUN;
          end
        end
        HZ_MEM_WAIT: w_state_nxt = (r_flush_left != 3'd0) ? HZ_REDIRECT : HZ_RUN;
        default:     w_state_nxt = HZ_RUN;
      endcase
    end
  end

  // Outputs: reset forces a bubble, then memory stall > redirect > REDIRECT squash / load-use.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_hold = 1'b0;
    pc_redirect = 1'b0;
    if (!RST_N) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_mem_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ex_mem_hold = 1'b1;
    end else if (w_redirect) begin
      pc_redirect = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      // A MEM_WAIT ack cycle behaves as RUN; owed squashes resume next cycle.
      if (r_state == HZ_REDIRECT) begin
        if_id_flush = 1'b1;
      end
      // Load-use: hold PC and IF/ID one cycle, inject a bubble into ID/EX.
      if (w_load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Saturating event counters: stalled cycles and accepted redirects.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (!pc_write && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
      if (w_redirect_evt && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
  assign state       = r_state;

endmodule
